// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose: ID-stage RAW hazard detection using a per-register scoreboard of
// countdown counters. Every committed register write loads the destination
// entry with PIPE_DEPTH. The entry then counts down once per non-stalled
// cycle while the producer moves through EXE/MEM. A consumer that reads a
// pending register stalls at the ID/EXE boundary:
//   - forwarding on : only when the producer is a load issued directly ahead
//   - forwarding off: on any pending producer.
// A saturating counter records how many cycles were spent stalled.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   issue_valid      ID holds a valid instruction
//   src_addr         NUM_SRC packed source addresses (src s at s*REG_ADDR_W)
//   src_valid        per-source "operand actually read"
//   dest_addr        destination register of the ID instruction
//   dest_wb_en       ID instruction writes dest_addr
//   dest_is_load     ID instruction is a memory load
//   ignore_hazard    forces hazard_detected low
//   forwarding_en    1 = load-use stalls only, 0 = stall on any pending producer
//   mem_stall        pipeline frozen; scoreboard and stall counter hold
//   flush            ID instruction discarded
//   hazard_detected  stall ID / bubble into EXE (combinational)
//   pending_mask     bit r set while register r has an in-flight producer
//   stall_cycles     saturating stall-cycle count
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 4,
    parameter int NUM_SRC     = 2,
    parameter int PIPE_DEPTH  = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [REG_ADDR_W-1:0]         dest_addr,
    input  logic                          dest_wb_en,
    input  logic                          dest_is_load,
    input  logic                          ignore_hazard,
    input  logic                          forwarding_en,
    input  logic                          mem_stall,
    input  logic                          flush,
    output logic                          hazard_detected,
    output logic [(2**REG_ADDR_W)-1:0]    pending_mask,
    output logic [STALL_CNT_W-1:0]        stall_cycles
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    // Counters are 3 bits wide, so the depth must fit in 1..7.
    localparam logic [2:0] DEPTH = 3'(PIPE_DEPTH);

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 7) begin : g_bad_depth
        $error("hazard_scoreboard: PIPE_DEPTH must be in 1..7");
    end

    logic [2:0]          r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] r_ld;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [NUM_SRC-1:0]  w_conflict;
    logic                w_hazard;
    logic                w_commit;

    // Per-source conflict check against registered state only; the ID
    // instruction's own destination is not yet in the scoreboard, so a
    // source equal to dest_addr can never hazard against itself.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_ADDR_W-1:0] w_src;
        logic                  w_busy;
        logic                  w_load_use;
        assign w_src      = src_addr[gi*REG_ADDR_W +: REG_ADDR_W];
        assign w_busy     = (r_cnt[w_src] != 3'd0);
        // A load that has just entered EXE cannot be forwarded yet.
        assign w_load_use = r_ld[w_src] & (r_cnt[w_src] == DEPTH);
        assign w_conflict[gi] = issue_valid & src_valid[gi] & w_busy
                              & (~forwarding_en | w_load_use);
    end

    assign w_hazard = ~ignore_hazard & (|w_conflict);
    assign w_commit = issue_valid & ~w_hazard & ~flush & ~mem_stall & dest_wb_en;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
        assign pending_mask[gi] = (r_cnt[gi] != 3'd0);
    end

    // Scoreboard update. A commit reloads its entry and takes priority over
    // the decrement, so the newest producer of a register always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= 3'd0;
            end
            r_ld <= '0;
        end else if (!mem_stall) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (dest_addr == REG_ADDR_W'(i))) begin
                    r_cnt[i] <= DEPTH;
                    r_ld[i]  <= dest_is_load;
                end else if (r_cnt[i] != 3'd0) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    // Stall counter only advances on cycles where the stall actually costs
    // a pipeline slot (not while memory has frozen everything anyway).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !mem_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hazard_detected = w_hazard;
    assign stall_cycles    = r_stall_cnt;

endmodule
